// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared types and constants for the CPU phase sequencer and the blocks it drives.
// Optional single-step support is enabled by defining SINGLE_STEP_EN.
package cpu_phase_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_STALL = 2'd2
    } seq_state_e;

    // Default phase numbers consumed by fetch, decode, alu and writeback.
    localparam int unsigned PH_FETCH  = 0;
    localparam int unsigned PH_DECODE = 1;
    localparam int unsigned PH_ALU    = 4;
    localparam int unsigned PH_WB     = 5;

    // Successor of a phase index with wrap at num_phases-1.
    function automatic int unsigned next_phase(input int unsigned cur, input int unsigned num_phases);
        return (cur == num_phases - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/cpu_phase_sequencer_phase_counter.sv
// Wrap-around modulo-NUM_PHASES phase counter with hold, plus one-hot decode of the count.
// Used by cpu_phase_sequencer in both SINGLE_STEP_EN and default builds.
module phase_counter
    import cpu_phase_sequencer_pkg::*;
#(
    parameter int unsigned NUM_PHASES = 8,
    parameter int unsigned PHASE_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  advance,
    output logic [PHASE_W-1:0]    idx,
    output logic [NUM_PHASES-1:0] onehot_c
);

    localparam int unsigned LAST = NUM_PHASES - 1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx <= '0;
        end else if (advance) begin
            idx <= (idx == PHASE_W'(LAST)) ? '0 : idx + PHASE_W'(1);
        end
    end

    // Decode by comparison so PHASE_W may exceed clog2(NUM_PHASES).
    always_comb begin
        onehot_c = '0;
        for (int unsigned k = 0; k < NUM_PHASES; k++) begin
            onehot_c[k] = (idx == PHASE_W'(k));
        end
    end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Instruction-cycle phase sequencer: one-hot phase enables, run/halt, stall hold, instruction counter.
// Define SINGLE_STEP_EN to let a step_req pulse in IDLE run exactly one instruction.
module cpu_phase_sequencer
    import cpu_phase_sequencer_pkg::*;
#(
    parameter int unsigned NUM_PHASES = 8,
    parameter int unsigned PHASE_W    = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  stall,
    input  logic                  step_req,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic [PHASE_W-1:0]    phase_idx,
    output logic                  instr_done,
    output logic                  busy,
    output logic [CNT_W-1:0]      instr_count
);

    localparam int unsigned LAST = NUM_PHASES - 1;

    seq_state_e            state;
    logic                  step_mode;
    logic                  step_go;
    logic                  active_c;
    logic                  issue_c;
    logic                  last_c;
    logic [NUM_PHASES-1:0] onehot_c;

`ifdef SINGLE_STEP_EN
    assign step_go = step_req;
`else
    logic unused_step_req;
    assign unused_step_req = step_req;
    assign step_go         = 1'b0;
`endif

    assign active_c = (state != SEQ_IDLE);
    assign issue_c  = active_c && !stall;
    assign last_c   = (phase_idx == PHASE_W'(LAST));

    phase_counter #(
        .NUM_PHASES (NUM_PHASES),
        .PHASE_W    (PHASE_W)
    ) u_phase_counter (
        .clk      (clk),
        .reset    (reset),
        .advance  (issue_c),
        .idx      (phase_idx),
        .onehot_c (onehot_c)
    );

    // Sequencer FSM; a stalled edge issues nothing and leaves the pending phase in the counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= SEQ_IDLE;
            step_mode   <= 1'b0;
            phase_en    <= '0;
            instr_done  <= 1'b0;
            busy        <= 1'b0;
            instr_count <= '0;
        end else begin
            phase_en   <= '0;
            instr_done <= 1'b0;
            busy       <= active_c;
            case (state)
                SEQ_IDLE: begin
                    if (run) begin
                        state     <= SEQ_RUN;
                        step_mode <= 1'b0;
                    end else if (step_go) begin
                        state     <= SEQ_RUN;
                        step_mode <= 1'b1;
                    end
                end
                SEQ_RUN, SEQ_STALL: begin
                    if (stall) begin
                        state <= SEQ_STALL;
                    end else begin
                        phase_en <= onehot_c;
                        state    <= SEQ_RUN;
                        if (last_c) begin
                            instr_done  <= 1'b1;
                            instr_count <= instr_count + CNT_W'(1);
                            // Halt only at the instruction boundary.
                            if (!run || step_mode) begin
                                state <= SEQ_IDLE;
                            end
                        end
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Scoreboard bench for cpu_phase_sequencer: two instances (8-phase/16-bit count, 2-phase/4-bit count)
// share stimulus; a behavioural model predicts every cycle and a monitor compares at the falling edge.
module tb_cpu_phase_sequencer;

    localparam int unsigned NA = 8;
    localparam int unsigned PWA = 4;
    localparam int unsigned CWA = 16;
    localparam int unsigned NB = 2;
    localparam int unsigned PWB = 1;
    localparam int unsigned CWB = 4;
`ifdef SINGLE_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    logic run;
    logic stall;
    logic step_req;

    logic [NA-1:0]  a_phase_en;
    logic [PWA-1:0] a_phase_idx;
    logic           a_instr_done;
    logic           a_busy;
    logic [CWA-1:0] a_instr_count;
    logic [NB-1:0]  b_phase_en;
    logic [PWB-1:0] b_phase_idx;
    logic           b_instr_done;
    logic           b_busy;
    logic [CWB-1:0] b_instr_count;

    cpu_phase_sequencer #(.NUM_PHASES(NA), .PHASE_W(PWA), .CNT_W(CWA)) dut_a (
        .clk(clk), .reset(reset), .run(run), .stall(stall), .step_req(step_req),
        .phase_en(a_phase_en), .phase_idx(a_phase_idx), .instr_done(a_instr_done),
        .busy(a_busy), .instr_count(a_instr_count)
    );

    cpu_phase_sequencer #(.NUM_PHASES(NB), .PHASE_W(PWB), .CNT_W(CWB)) dut_b (
        .clk(clk), .reset(reset), .run(run), .stall(stall), .step_req(step_req),
        .phase_en(b_phase_en), .phase_idx(b_phase_idx), .instr_done(b_instr_done),
        .busy(b_busy), .instr_count(b_instr_count)
    );

    // Expected outputs visible after edge number cyc.
    typedef struct {
        int unsigned cyc;
        logic [15:0] en;
        int unsigned idx;
        bit          done;
        bit          busy;
        int unsigned cnt;
    } exp_t;

    // Abstract view: is an instruction in progress, which phase comes next, how many finished.
    typedef struct {
        bit          active;
        bit          stepping;
        int unsigned next;
        int unsigned count;
    } mdl_t;

    typedef struct {
        int unsigned cyc;
        int unsigned sel;
        logic [63:0] val;
    } dir_t;

    exp_t qa[$];
    exp_t qb[$];
    dir_t dq[$];
    mdl_t ma;
    mdl_t mb;
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    function automatic exp_t model_step(inout mdl_t m, input int unsigned n, input int unsigned cw,
                                        input int unsigned stamp, input bit rst_n, input bit go,
                                        input bit hold, input bit step);
        exp_t e;
        e.cyc  = stamp;
        e.en   = '0;
        e.done = 1'b0;
        e.busy = 1'b0;
        if (!rst_n) begin
            m.active   = 1'b0;
            m.stepping = 1'b0;
            m.next     = 0;
            m.count    = 0;
        end else if (!m.active) begin
            if (go) begin
                m.active   = 1'b1;
                m.stepping = 1'b0;
            end else if (step) begin
                m.active   = 1'b1;
                m.stepping = 1'b1;
            end
        end else begin
            e.busy = 1'b1;
            if (!hold) begin
                e.en = 16'(1) << m.next;
                if (m.next == n - 1) begin
                    e.done  = 1'b1;
                    m.count = (m.count + 1) % (1 << cw);
                    if (!go || m.stepping) m.active = 1'b0;
                end
                m.next = (m.next + 1) % n;
            end
        end
        e.idx = m.next;
        e.cnt = m.count;
        return e;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, expv);
        end
    endfunction

    task automatic tick();
        qa.push_back(model_step(ma, NA, CWA, cyc + 1, reset, run, stall, step_req & STEP_EN));
        qb.push_back(model_step(mb, NB, CWB, cyc + 1, reset, run, stall, step_req & STEP_EN));
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic expect_now(input int unsigned sel, input logic [63:0] val);
        dir_t d;
        d.cyc = cyc;
        d.sel = sel;
        d.val = val;
        dq.push_back(d);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin : monitor
        exp_t ea;
        exp_t eb;
        dir_t d;
        if (cyc > 0) begin
            if (qa.size() == 0 || qb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_underflow: cycle %0d got %0d/%0d entries expected >0", cyc, qa.size(), qb.size());
            end else begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk("a_phase_en",    64'(a_phase_en),    64'(ea.en));
                chk("a_phase_idx",   64'(a_phase_idx),   64'(ea.idx));
                chk("a_instr_done",  64'(a_instr_done),  64'(ea.done));
                chk("a_busy",        64'(a_busy),        64'(ea.busy));
                chk("a_instr_count", 64'(a_instr_count), 64'(ea.cnt));
                chk("b_phase_en",    64'(b_phase_en),    64'(eb.en));
                chk("b_phase_idx",   64'(b_phase_idx),   64'(eb.idx));
                chk("b_instr_done",  64'(b_instr_done),  64'(eb.done));
                chk("b_busy",        64'(b_busy),        64'(eb.busy));
                chk("b_instr_count", 64'(b_instr_count), 64'(eb.cnt));
            end
            while (dq.size() > 0 && dq[0].cyc <= cyc) begin
                d = dq.pop_front();
                case (d.sel)
                    0: chk("dir_a_instr_count", 64'(a_instr_count), d.val);
                    1: chk("dir_b_instr_count", 64'(b_instr_count), d.val);
                    2: chk("dir_a_phase_idx",   64'(a_phase_idx),   d.val);
                    3: chk("dir_b_phase_idx",   64'(b_phase_idx),   d.val);
                    default: chk("dir_a_busy",  64'(a_busy),        d.val);
                endcase
            end
        end
    end

    initial begin
        reset    = 1'b0;
        run      = 1'b1;
        stall    = 1'b0;
        step_req = 1'b0;

        // Reset held with run high.
        repeat (3) tick();
        expect_now(0, 64'd0);
        expect_now(2, 64'd0);
        expect_now(4, 64'd0);

        // Free run: one arming edge, then 24 phases.
        reset = 1'b1;
        repeat (25) tick();
        expect_now(0, 64'd3);
        expect_now(1, 64'd12);

        // Stall four edges while phase 3 is pending.
        for (int i = 0; i < 20 && ma.next != 3; i++) tick();
        stall = 1'b1;
        repeat (4) tick();
        expect_now(2, 64'd3);
        expect_now(4, 64'd1);
        stall = 1'b0;
        for (int i = 0; i < 20 && ma.next != 0; i++) tick();
        expect_now(0, 64'd4);

        // Drop run mid-instruction: remaining phases still issue, then idle.
        for (int i = 0; i < 20 && ma.next != 3; i++) tick();
        run = 1'b0;
        for (int i = 0; i < 20 && ma.active; i++) tick();
        expect_now(0, 64'd5);
        expect_now(4, 64'd1);
        tick();
        expect_now(4, 64'd0);
        expect_now(2, 64'd0);
        repeat (3) tick();

`ifdef SINGLE_STEP_EN
        // Single step, with a second request mid-instruction that must be ignored.
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        for (int i = 0; i < 20 && ma.next != 4; i++) tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        for (int i = 0; i < 20 && ma.active; i++) tick();
        expect_now(0, 64'd6);
        tick();
        expect_now(4, 64'd0);
        repeat (3) tick();
`else
        // Without single-step support a step pulse does nothing.
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        repeat (4) tick();
        expect_now(4, 64'd0);
        expect_now(0, 64'd5);
`endif

        // Counter wrap on the 2-phase, 4-bit instance: 15 -> 0 -> 1.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        run   = 1'b1;
        tick();
        repeat (30) tick();
        expect_now(1, 64'd15);
        repeat (2) tick();
        expect_now(1, 64'd0);
        repeat (2) tick();
        expect_now(1, 64'd1);

        // Reset while phase 1 is pending.
        for (int i = 0; i < 4 && mb.next != 1; i++) tick();
        reset = 1'b0;
        tick();
        expect_now(1, 64'd0);
        expect_now(3, 64'd0);
        expect_now(0, 64'd0);
        reset = 1'b1;

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            run      = ($urandom_range(7) != 0);
            stall    = ($urandom_range(3) == 0);
            step_req = ($urandom_range(15) == 0);
            reset    = ($urandom_range(127) != 0);
            tick();
        end

        reset    = 1'b1;
        run      = 1'b0;
        stall    = 1'b0;
        step_req = 1'b0;
        repeat (40) tick();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
